audio_dac_serializer: RTL and testbench



---
 rtl/audio_pkg.sv | 21 ++
 rtl/audio_sample_fifo.sv | 78 +++++++
 rtl/audio_dac_serializer.sv | 140 ++++++++++++++
 tb/tb_audio_dac_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and defaults for the audio playback path.
//   AUDIO_DATA_WIDTH / AUDIO_FIFO_DEPTH : default sample width and FIFO depth
//   frame_state_t                       : DAC frame FSM states
//   stereo_sample_t                     : {left, right} pair at the default width
package audio_pkg;

  localparam int unsigned AUDIO_DATA_WIDTH = 16;
  localparam int unsigned AUDIO_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } frame_state_t;

  typedef struct packed {
    logic [AUDIO_DATA_WIDTH-1:0] left;
    logic [AUDIO_DATA_WIDTH-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: single-clock FIFO of stereo pairs, first-word fall-through.
//   clk, rst_n      : clock, synchronous active-low reset (pointers/count only)
//   push, push_data : write request and pair; ignored while full
//   pop, pop_data   : read request; pop_data always shows the head entry
//   full, empty     : occupancy flags
//   space           : free slots (DEPTH when empty)
// DEPTH must be a power of two so pointers wrap modulo DEPTH naturally.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter type         T     = stereo_sample_t,
  parameter int unsigned DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] space
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign space    = DEPTH_C - count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: streams buffered stereo PCM to the WM8731 DAC input.
//   CLOCK_50               : system clock, all logic in this domain
//   reset                  : synchronous active-low reset
//   AUD_BCLK, AUD_DACLRCK  : codec master clocks, asynchronous, synchronised here
//   AUD_DACDAT             : serial data, MSB first, changes after BCLK falls
//   left/right_channel_audio_in, write_audio_out : pair push interface
//   audio_out_allowed      : FIFO not full
//   fifo_space             : free pair slots
//   underrun               : one-cycle pulse when a frame starts with no data
// Build option: AUDIO_DAC_I2S_EN selects I2S framing (left = LRCK low, MSB
// delayed one BCLK); left-justified framing otherwise.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT,
  input  logic [DATA_WIDTH-1:0]       left_channel_audio_in,
  input  logic [DATA_WIDTH-1:0]       right_channel_audio_in,
  input  logic                        write_audio_out,
  output logic                        audio_out_allowed,
  output logic [$clog2(FIFO_DEPTH):0] fifo_space,
  output logic                        underrun
);

  // Width-matched form of stereo_sample_t so DATA_WIDTH can be overridden.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  logic [2:0]      bclk_sync_q, bclk_sync_d;
  logic [2:0]      lrck_sync_q, lrck_sync_d;
  logic            bclk_fall, lrck_rise, lrck_fall;
  logic            frame_start, chan_switch;

  frame_state_t    state_q, state_d;
  // One extra bit above the word: the top bit drives the pin, so a load can
  // present either the MSB at once or a leading zero for I2S.
  logic [DATA_WIDTH:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0] right_hold_q, right_hold_d;
  logic                  underrun_q, underrun_d;

  pair_t push_pair, head_pair, frame_pair;
  logic  fifo_full, fifo_empty, pop;

  function automatic logic [DATA_WIDTH:0] load_word(input logic [DATA_WIDTH-1:0] w);
`ifdef AUDIO_DAC_I2S_EN
    return {1'b0, w};
`else
    return {w, 1'b0};
`endif
  endfunction

  // Two synchronising flops plus one history flop per codec clock.
  // Not reset, so an LRCK level held across reset cannot look like an edge.
  assign bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
  assign lrck_sync_d = {lrck_sync_q[1:0], AUD_DACLRCK};

  always_ff @(posedge CLOCK_50) begin
    bclk_sync_q <= bclk_sync_d;
    lrck_sync_q <= lrck_sync_d;
  end

  assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lrck_rise = lrck_sync_q[1] & ~lrck_sync_q[2];
  assign lrck_fall = lrck_sync_q[2] & ~lrck_sync_q[1];

`ifdef AUDIO_DAC_I2S_EN
  assign frame_start = lrck_fall;
  assign chan_switch = lrck_rise;
`else
  assign frame_start = lrck_rise;
  assign chan_switch = lrck_fall;
`endif

  assign push_pair.left  = left_channel_audio_in;
  assign push_pair.right = right_channel_audio_in;

  audio_sample_fifo #(
    .T     (pair_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (reset),
    .push      (write_audio_out),
    .push_data (push_pair),
    .pop       (pop),
    .pop_data  (head_pair),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .space     (fifo_space)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    right_hold_d = right_hold_q;
    underrun_d   = 1'b0;
    pop          = 1'b0;
    frame_pair   = fifo_empty ? '0 : head_pair;
    // LRCK loads win over a coincident bclk_fall: the shift is skipped.
    if (frame_start) begin
      pop          = !fifo_empty;
      underrun_d   = fifo_empty;
      state_d      = LEFT;
      shift_d      = load_word(frame_pair.left);
      right_hold_d = frame_pair.right;
    end else if (chan_switch && state_q == LEFT) begin
      state_d = RIGHT;
      shift_d = load_word(right_hold_q);
    end else if (bclk_fall) begin
      shift_d = {shift_q[DATA_WIDTH-1:0], 1'b0};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      right_hold_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      right_hold_q <= right_hold_d;
      underrun_q   <= underrun_d;
    end
  end

  assign AUD_DACDAT        = shift_q[DATA_WIDTH];
  assign audio_out_allowed = !fifo_full;
  assign underrun          = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: directed bench for audio_dac_serializer.
// Drives BCLK = CLOCK_50/16 with 32 BCLKs per channel and samples AUD_DACDAT
// at each BCLK rise, as the codec would. Honours AUDIO_DAC_I2S_EN.
module tb_audio_dac_serializer;

`ifdef AUDIO_DAC_I2S_EN
  localparam logic FIRST_LVL = 1'b0;
`else
  localparam logic FIRST_LVL = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bclk, lrck, write;
  logic [15:0] l_in, r_in;
  logic        dacdat, allowed, underrun;
  logic [3:0]  space;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          uruns;
  logic [3:0]  space_mid, space_after;

  always #10 clk = ~clk;

  audio_dac_serializer #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (8)
  ) dut (
    .CLOCK_50               (clk),
    .reset                  (reset_n),
    .AUD_BCLK               (bclk),
    .AUD_DACLRCK            (lrck),
    .AUD_DACDAT             (dacdat),
    .left_channel_audio_in  (l_in),
    .right_channel_audio_in (r_in),
    .write_audio_out        (write),
    .audio_out_allowed      (allowed),
    .fifo_space             (space),
    .underrun               (underrun)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
`ifdef AUDIO_DAC_I2S_EN
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
`else
    return {l, 16'b0, r, 16'b0};
`endif
  endfunction

  function automatic logic [15:0] pl(input int i);
    return 16'(32'h1111 * i);
  endfunction

  function automatic logic [15:0] pr(input int i);
    return ~pl(i);
  endfunction

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    l_in  = l;
    r_in  = r;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  // One BCLK period: fall (optional LRCK change), 8 cycles low, rise, 8 high.
  // push_cyc >= 1 pulses write for one cycle at that point of the low phase.
  task automatic one_bit(input logic do_lrck, input logic lvl, input int push_cyc,
                         output logic sample);
    @(negedge clk);
    bclk = 1'b0;
    if (do_lrck) lrck = lvl;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (underrun) uruns++;
      if (k == push_cyc) begin
        space_mid = space;
        write     = 1'b1;
      end else if (k == push_cyc + 1) begin
        write       = 1'b0;
        space_after = space;
      end
    end
    @(negedge clk);
    if (underrun) uruns++;
    sample = dacdat;
    bclk   = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if (underrun) uruns++;
    end
  endtask

  task automatic play_frame(input int push_cyc, output logic [63:0] bits);
    uruns = 0;
    for (int b = 0; b < 64; b++) begin
      logic s;
      one_bit(b == 0 || b == 32, (b < 32) ? FIRST_LVL : ~FIRST_LVL,
              (b == 0) ? push_cyc : -1, s);
      bits[63-b] = s;
    end
  endtask

  initial begin
    logic [63:0] bits;
    logic [63:0] rest;
    logic        s;

    reset_n = 1'b0;
    bclk    = 1'b1;
    lrck    = ~FIRST_LVL;
    write   = 1'b0;
    l_in    = '0;
    r_in    = '0;
    space_mid   = '0;
    space_after = '0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_dacdat",   64'(dacdat),   64'd0);
    check_eq("rst_allowed",  64'(allowed),  64'd1);
    check_eq("rst_space",    64'(space),    64'd8);
    check_eq("rst_underrun", 64'(underrun), 64'd0);

    // Single frame, two patterns.
    push_pair(16'hA5C3, 16'h0F0F);
    check_eq("space_after_push", 64'(space), 64'd7);
    play_frame(-1, bits);
    check_eq("frame_a5c3", bits, exp_frame(16'hA5C3, 16'h0F0F));
    check_eq("frame_a5c3_urun", 64'(uruns), 64'd0);
    check_eq("space_after_pop", 64'(space), 64'd8);
    push_pair(16'h8001, 16'h7FFE);
    play_frame(-1, bits);
    check_eq("frame_8001", bits, exp_frame(16'h8001, 16'h7FFE));

    // Fill past full: ninth pair must be dropped.
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 2) check_eq("fill_space1", 64'(space), 64'd7);
      if (i == 9) begin
        check_eq("fill_space8", 64'(space), 64'd0);
        check_eq("fill_allowed8", 64'(allowed), 64'd0);
      end
      l_in  = pl(i);
      r_in  = pr(i);
      write = 1'b1;
    end
    @(negedge clk);
    write = 1'b0;
    check_eq("full_space", 64'(space), 64'd0);
    check_eq("full_allowed", 64'(allowed), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      play_frame(-1, bits);
      check_eq($sformatf("fill_frame%0d", i), bits, exp_frame(pl(i), pr(i)));
      check_eq($sformatf("fill_urun%0d", i), 64'(uruns), 64'd0);
    end
    play_frame(-1, bits);
    check_eq("empty_frame", bits, 64'd0);
    check_eq("empty_urun", 64'(uruns), 64'd1);

    // Push coincident with the frame-start pop at space 3.
    for (int i = 11; i <= 15; i++) push_pair(pl(i), pr(i));
    check_eq("pp_space_before", 64'(space), 64'd3);
    l_in = pl(16);
    r_in = pr(16);
    play_frame(2, bits);
    check_eq("pp_frame11", bits, exp_frame(pl(11), pr(11)));
    check_eq("pp_space_mid", 64'(space_mid), 64'd3);
    check_eq("pp_space_after", 64'(space_after), 64'd3);
    check_eq("pp_space_end", 64'(space), 64'd3);
    for (int i = 12; i <= 16; i++) begin
      play_frame(-1, bits);
      check_eq($sformatf("pp_frame%0d", i), bits, exp_frame(pl(i), pr(i)));
    end

    // Reset in the middle of the left channel.
    push_pair(16'hFFFF, 16'hFFFF);
    push_pair(16'h1234, 16'h4321);
    for (int b = 0; b < 5; b++) one_bit(b == 0, FIRST_LVL, -1, s);
    check_eq("pre_reset_dat", 64'(dacdat), 64'd1);
    check_eq("pre_reset_space", 64'(space), 64'd7);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_reset_dat", 64'(dacdat), 64'd0);
    check_eq("mid_reset_space", 64'(space), 64'd8);
    reset_n = 1'b1;
    uruns = 0;
    rest  = '0;
    for (int b = 5; b < 64; b++) begin
      one_bit(b == 32, ~FIRST_LVL, -1, s);
      rest[63-b] = s;
    end
    check_eq("post_reset_idle", rest, 64'd0);
    check_eq("post_reset_idle_urun", 64'(uruns), 64'd0);
    play_frame(-1, bits);
    check_eq("post_reset_frame", bits, 64'd0);
    check_eq("post_reset_urun", 64'(uruns), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
